// File: rtl/wb_stage.sv
// Writeback stage: registers the execute-to-writeback bus, commits results into an
// integrated register file (r0 hardwired to zero), serves two combinational read ports
// with write-through bypass, drives the second forwarding bus and counts retirements.
// Optional commit trace with backpressure is enabled by defining WB_TRACE_EN.
module wb_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NREG   = 32,
   parameter int unsigned CNT_W  = 32
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                es_to_ws_valid,
   input  logic [DATA_W+37:0]  es_to_ws_bus,
   output logic                ws_allowin,
   input  logic [4:0]          rf_raddr1,
   input  logic [4:0]          rf_raddr2,
   output logic [DATA_W-1:0]   rf_rdata1,
   output logic [DATA_W-1:0]   rf_rdata2,
   output logic [DATA_W+4:0]   ws_forward_bus,
   output logic [CNT_W-1:0]    retire_cnt
`ifdef WB_TRACE_EN
   ,
   output logic                trace_valid,
   input  logic                trace_ready,
   output logic [DATA_W+37:0]  trace_bus
`endif
);

   localparam int unsigned BusW = DATA_W + 38;

   logic              ws_valid_q, ws_valid_d;
   logic [BusW-1:0]   ws_bus_q, ws_bus_d;
   logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
   logic [DATA_W-1:0] rf_q [NREG];

   logic              ws_ready_go;
   logic              commit;
   logic              rf_we;
   logic              ws_gr_we;
   logic [4:0]        ws_dest;
   logic [DATA_W-1:0] ws_result;

   // Bus field extraction: {gr_we, dest, result, pc}
   assign ws_gr_we  = ws_bus_q[DATA_W+37];
   assign ws_dest   = ws_bus_q[DATA_W+36:DATA_W+32];
   assign ws_result = ws_bus_q[DATA_W+31:32];

`ifdef WB_TRACE_EN
   // The consumer's ready gates the commit so the trace never drops an instruction.
   assign ws_ready_go = trace_ready;
   assign trace_valid = ws_valid_q;
   assign trace_bus   = ws_bus_q;
`else
   assign ws_ready_go = 1'b1;
   // The pc field is only consumed by the trace port.
   logic unused_pc;
   assign unused_pc = ^ws_bus_q[31:0];
`endif

   assign ws_allowin = !ws_valid_q || ws_ready_go;
   assign commit     = ws_valid_q && ws_ready_go;
   assign rf_we      = commit && ws_gr_we && (ws_dest != 5'd0);
   assign retire_cnt = retire_cnt_q;

   // Next-state for the stage register and retire counter.
   always_comb begin
      ws_valid_d   = ws_valid_q;
      ws_bus_d     = ws_bus_q;
      retire_cnt_d = retire_cnt_q;
      if (ws_allowin) begin
         ws_valid_d = es_to_ws_valid;
         ws_bus_d   = es_to_ws_bus;
      end
      if (commit) begin
         retire_cnt_d = retire_cnt_q + 1'b1;
      end
   end

   // Stage valid, bus and retire counter state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ws_valid_q   <= 1'b0;
         ws_bus_q     <= '0;
         retire_cnt_q <= '0;
      end else begin
         ws_valid_q   <= ws_valid_d;
         ws_bus_q     <= ws_bus_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   // Register file array; entry 0 is never written so it stays zero.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
      end else if (rf_we) begin
         rf_q[ws_dest] <= ws_result;
      end
   end

   // Read port 1 with write-through bypass of the committing result.
   always_comb begin
      rf_rdata1 = rf_q[rf_raddr1];
      if (rf_raddr1 == 5'd0) begin
         rf_rdata1 = '0;
      end else if (rf_we && (rf_raddr1 == ws_dest)) begin
         rf_rdata1 = ws_result;
      end
   end

   // Read port 2 with write-through bypass of the committing result.
   always_comb begin
      rf_rdata2 = rf_q[rf_raddr2];
      if (rf_raddr2 == 5'd0) begin
         rf_rdata2 = '0;
      end else if (rf_we && (rf_raddr2 == ws_dest)) begin
         rf_rdata2 = ws_result;
      end
   end

   // Forwarding bus is zero unless a register write is actually committing.
   always_comb begin
      ws_forward_bus = '0;
      if (rf_we) begin
         ws_forward_bus = {ws_result, ws_dest};
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: table-driven single-instruction vectors plus
// hand-written sequences for back-to-back writes, counter wrap, async reset and
// (with WB_TRACE_EN) trace backpressure.
module tb_wb_stage;

   logic        clk;
   logic        resetn;
   logic        es_to_ws_valid;
   logic [69:0] es_to_ws_bus;
   logic        ws_allowin;
   logic [4:0]  rf_raddr1;
   logic [4:0]  rf_raddr2;
   logic [31:0] rf_rdata1;
   logic [31:0] rf_rdata2;
   logic [36:0] ws_forward_bus;
   logic [31:0] retire_cnt;
`ifdef WB_TRACE_EN
   logic        trace_valid;
   logic        trace_ready;
   logic [69:0] trace_bus;
`endif

   int n_cmp;
   int n_err;
   logic [31:0] exp_cnt;

   wb_stage dut (
      .clk            (clk),
      .resetn         (resetn),
      .es_to_ws_valid (es_to_ws_valid),
      .es_to_ws_bus   (es_to_ws_bus),
      .ws_allowin     (ws_allowin),
      .rf_raddr1      (rf_raddr1),
      .rf_raddr2      (rf_raddr2),
      .rf_rdata1      (rf_rdata1),
      .rf_rdata2      (rf_rdata2),
      .ws_forward_bus (ws_forward_bus),
      .retire_cnt     (retire_cnt)
`ifdef WB_TRACE_EN
      ,
      .trace_valid    (trace_valid),
      .trace_ready    (trace_ready),
      .trace_bus      (trace_bus)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  dest;
      logic [31:0] result;
      logic [31:0] pc;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [36:0] fwd;
      logic [31:0] rd1;
      logic [31:0] rd2;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one instruction onto the input bus (call at a negedge).
   task automatic drive(input logic we, input logic [4:0] dest, input logic [31:0] res,
                        input logic [31:0] pc);
      es_to_ws_valid = 1'b1;
      es_to_ws_bus   = {we, dest, res, pc};
   endtask

   task automatic idle();
      es_to_ws_valid = 1'b0;
      es_to_ws_bus   = '0;
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      exp_cnt   = 0;
      resetn    = 1'b0;
      rf_raddr1 = 5'd5;
      rf_raddr2 = 5'd31;
      idle();
`ifdef WB_TRACE_EN
      trace_ready = 1'b1;
`endif

      vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 32'h0000_1000, 5'd5,  5'd0,
                  {32'hDEADBEEF, 5'd5}, 32'hDEADBEEF, 32'h0};
      vecs[1] = '{1'b1, 5'd0,  32'h0000_1234, 32'h0000_1004, 5'd0,  5'd5,
                  37'h0, 32'h0, 32'hDEADBEEF};
      vecs[2] = '{1'b0, 5'd6,  32'h0000_AAAA, 32'h0000_1008, 5'd6,  5'd5,
                  37'h0, 32'h0, 32'hDEADBEEF};
      vecs[3] = '{1'b1, 5'd31, 32'hCAFE_0001, 32'h0000_100C, 5'd31, 5'd31,
                  {32'hCAFE_0001, 5'd31}, 32'hCAFE_0001, 32'hCAFE_0001};
      vecs[4] = '{1'b1, 5'd5,  32'h0000_0011, 32'h0000_1010, 5'd5,  5'd31,
                  {32'h0000_0011, 5'd5}, 32'h0000_0011, 32'hCAFE_0001};

      // Reset state
      #1;
      check("rst_allowin", {69'h0, ws_allowin}, 70'h1);
      check("rst_fwd", {33'h0, ws_forward_bus}, 70'h0);
      check("rst_cnt", {38'h0, retire_cnt}, 70'h0);
      check("rst_rd1", {38'h0, rf_rdata1}, 70'h0);
      check("rst_rd2", {38'h0, rf_rdata2}, 70'h0);
`ifdef WB_TRACE_EN
      check("rst_tvalid", {69'h0, trace_valid}, 70'h0);
      check("rst_tbus", trace_bus, 70'h0);
`endif
      @(negedge clk);
      resetn = 1'b1;

      // Table-driven single instructions: accept, then check in the commit cycle
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive(vecs[i].we, vecs[i].dest, vecs[i].result, vecs[i].pc);
         @(negedge clk);
         idle();
         rf_raddr1 = vecs[i].ra1;
         rf_raddr2 = vecs[i].ra2;
         #1;
         check($sformatf("vec%0d_fwd", i), {33'h0, ws_forward_bus}, {33'h0, vecs[i].fwd});
         check($sformatf("vec%0d_rd1", i), {38'h0, rf_rdata1}, {38'h0, vecs[i].rd1});
         check($sformatf("vec%0d_rd2", i), {38'h0, rf_rdata2}, {38'h0, vecs[i].rd2});
         exp_cnt = exp_cnt + 1;
         @(negedge clk);
         check($sformatf("vec%0d_cnt", i), {38'h0, retire_cnt}, {38'h0, exp_cnt});
      end

      // Array values after the table (no bypass in flight)
      rf_raddr1 = 5'd5;
      rf_raddr2 = 5'd6;
      #1;
      check("arr_r5", {38'h0, rf_rdata1}, {38'h0, 32'h0000_0011});
      check("arr_r6", {38'h0, rf_rdata2}, 70'h0);

      // Back-to-back writes to r7 with both ports reading r7
      rf_raddr1 = 5'd7;
      rf_raddr2 = 5'd7;
      drive(1'b1, 5'd7, 32'd1, 32'h2000);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k < 3) drive(1'b1, 5'd7, 32'(k + 1), 32'h2000 + 32'(4 * k));
         else idle();
         #1;
         check($sformatf("b2b%0d_rd1", k), {38'h0, rf_rdata1}, {38'h0, 32'(k)});
         check($sformatf("b2b%0d_rd2", k), {38'h0, rf_rdata2}, {38'h0, 32'(k)});
         check($sformatf("b2b%0d_allow", k), {69'h0, ws_allowin}, 70'h1);
         exp_cnt = exp_cnt + 1;
      end
      @(negedge clk);
      check("b2b_after_rd1", {38'h0, rf_rdata1}, {38'h0, 32'd3});
      check("b2b_after_fwd", {33'h0, ws_forward_bus}, 70'h0);
      check("b2b_cnt", {38'h0, retire_cnt}, {38'h0, exp_cnt});

      // Retire counter wrap
      force dut.retire_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.retire_cnt_q;
      #1;
      check("wrap_pre", {38'h0, retire_cnt}, {38'h0, 32'hFFFF_FFFF});
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 32'h3000);
      @(negedge clk);
      idle();
      @(negedge clk);
      check("wrap_cnt", {38'h0, retire_cnt}, 70'h0);
      exp_cnt = 0;

      // Asynchronous reset while a write to r9 is pending
      rf_raddr1 = 5'd9;
      rf_raddr2 = 5'd5;
      drive(1'b1, 5'd9, 32'h0000_0099, 32'h4000);
      @(negedge clk);
      idle();
      #1;
      check("prerst_fwd", {33'h0, ws_forward_bus}, {33'h0, 32'h99, 5'd9});
      #1;
      resetn = 1'b0;
      #1;
      check("arst_fwd", {33'h0, ws_forward_bus}, 70'h0);
      check("arst_allow", {69'h0, ws_allowin}, 70'h1);
      check("arst_cnt", {38'h0, retire_cnt}, 70'h0);
      check("arst_rd1", {38'h0, rf_rdata1}, 70'h0);
      check("arst_rd2", {38'h0, rf_rdata2}, 70'h0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check("post_rst_r9", {38'h0, rf_rdata1}, 70'h0);
      check("post_rst_cnt", {38'h0, retire_cnt}, 70'h0);

`ifdef WB_TRACE_EN
      // Trace backpressure: r3=0x55 held for 3 cycles, then commits
      rf_raddr1 = 5'd3;
      trace_ready = 1'b0;
      drive(1'b1, 5'd3, 32'h0000_0055, 32'h5000);
      @(negedge clk);
      idle();
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("stall%0d_allow", k), {69'h0, ws_allowin}, 70'h0);
         check($sformatf("stall%0d_tvalid", k), {69'h0, trace_valid}, 70'h1);
         check($sformatf("stall%0d_tbus", k), trace_bus,
               {1'b1, 5'd3, 32'h0000_0055, 32'h5000});
         check($sformatf("stall%0d_fwd", k), {33'h0, ws_forward_bus}, 70'h0);
         check($sformatf("stall%0d_r3", k), {38'h0, rf_rdata1}, 70'h0);
         check($sformatf("stall%0d_cnt", k), {38'h0, retire_cnt}, 70'h0);
         @(negedge clk);
      end
      trace_ready = 1'b1;
      #1;
      check("tr_commit_fwd", {33'h0, ws_forward_bus}, {33'h0, 32'h55, 5'd3});
      check("tr_commit_rd1", {38'h0, rf_rdata1}, {38'h0, 32'h55});
      check("tr_commit_allow", {69'h0, ws_allowin}, 70'h1);
      @(negedge clk);
      check("tr_after_cnt", {38'h0, retire_cnt}, 70'h1);
      check("tr_after_tvalid", {69'h0, trace_valid}, 70'h0);
      check("tr_after_r3", {38'h0, rf_rdata1}, {38'h0, 32'h55});
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final pipeline stage, directly downstream of the execute/memory stage.
- Registers the execute-to-writeback bus, writes results into an integrated 32x32 general register file, and serves the two combinational read ports used by decode.
- Drives the second forwarding bus (`forward_data2` of execute) and keeps a retired-instruction counter.
- Optionally emits a commit trace with backpressure.

Parameters:
- `DATA_W`, 32, register and result width.
- `NREG`, 32, number of architectural registers; register 0 is hardwired to zero.
- `CNT_W`, 32, width of the retire counter.

Ports:
- `clk`  in  1  single clock; all state is on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `es_to_ws_valid`  in  1  execute stage has an instruction for writeback.
- `es_to_ws_bus`  in  70  {gr_we[69], dest[68:64], result[63:32], pc[31:0]}.
- `ws_allowin`  out  1  writeback can accept this cycle.
- `rf_raddr1`  in  5  decode read address 1.
- `rf_raddr2`  in  5  decode read address 2.
- `rf_rdata1`  out  32  read data 1.
- `rf_rdata2`  out  32  read data 2.
- `ws_forward_bus`  out  37  {wdata[36:5], dest[4:0]}; all-zero when nothing is being written.
- `retire_cnt`  out  32  number of retired instructions.
- `trace_valid`  out  1  commit trace valid (`WB_TRACE_EN` only).
- `trace_ready`  in  1  trace consumer ready (`WB_TRACE_EN` only).
- `trace_bus`  out  70  {we, dest, wdata, pc} of the committing instruction (`WB_TRACE_EN` only).

Behaviour:
- Reset (`resetn` low, asynchronous):
  - `ws_valid`=0, stage bus register=0, all registers=0, `retire_cnt`=0, `trace_valid`=0.
  - All outputs are then 0, except `ws_allowin`=1.
  - Reset mid-instruction discards that instruction: no register write, no count.
- Handshake:
  - `ws_ready_go`=1 without the trace feature.
  - `ws_allowin` = `!ws_valid || (ws_ready_go)`.
  - When `ws_allowin`=1: `ws_valid` <= `es_to_ws_valid` and the bus register <= `es_to_ws_bus`.
  - When `ws_allowin`=0: both hold.
- Commit: an instruction commits in the cycle that `ws_valid && ws_ready_go`, one cycle after it is accepted.
  - `rf_we` = commit && `gr_we` && `dest`!=0.
  - On `rf_we`, `reg[dest]` <= result at the clock edge.
  - `retire_cnt` increments by 1 on every commit, whether or not the instruction writes a register.
  - `retire_cnt` wraps modulo 2^`CNT_W` (0xFFFFFFFF -> 0).
- Read ports:
  - Purely combinational; address 0 returns 0.
  - Write-through bypass: if `rf_we` and `raddr`==`dest`, the read returns the committing result in the same cycle.
  - Both ports may hit the same address and both bypass.
- Forwarding: `ws_forward_bus` = `rf_we` ? {result, dest} : 37'b0. This is combinational from the stage registers and valid in the commit cycle.
- Back-to-back writes:
  - Writes on consecutive cycles to the same register: the last one wins.
  - A read one cycle after a write returns the array value with no bypass needed.

Optional Feature:
- Macro: `WB_TRACE_EN`.
- With the macro defined:
  - `trace_valid` = `ws_valid`; `trace_bus` = the stage bus register.
  - `ws_ready_go` = `trace_ready`.
  - With `trace_ready`=0 the instruction does not commit: no register write, no count, forward bus zero, `ws_allowin`=0 while `ws_valid`=1, and `trace_valid`/`trace_bus` are held stable.
  - Commit happens in the cycle `trace_ready`=1.
- Without the macro: the `trace_*` ports are absent and `ws_ready_go`=1.

Test Plan:
- Release reset, send valid, `gr_we`=1, `dest`=5, result=0xDEADBEEF -> the next cycle shows `ws_forward_bus`={0xDEADBEEF,5} and a read of addr 5 bypasses 0xDEADBEEF; after that edge, `reg[5]`=0xDEADBEEF and `retire_cnt`=1.
- Write `dest`=0, result=0x1234 -> `ws_forward_bus`=0, a read of addr 0 returns 0, `retire_cnt` increments.
- Three back-to-back instructions writing `r7`=1, 2, 3, while both ports read `r7` every cycle -> reads return 1, 2, 3 in the commit cycles, and 3 afterwards.
- Force `retire_cnt` to 0xFFFFFFFF, then commit one instruction -> `retire_cnt`=0.
- Assert `resetn`=0 while `ws_valid`=1 with a pending write to `r9` -> `r9` stays 0, all outputs return to reset values immediately, without waiting for a clock edge.
- `WB_TRACE_EN`, `trace_ready`=0 for 3 cycles with a write to `r3`=0x55 pending -> `ws_allowin`=0, `r3` unchanged and the trace held for those cycles; with `trace_ready`=1, it commits in one cycle.
